rr_arbiter_4: RTL and testbench
===============================

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum consecutive cycles one requester keeps the grant (legal range 2..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  4  request lines; bit i = requester i.
REQ-005 Port: mode  input  1  0 = fixed priority, 1 = round-robin.
REQ-006 Port: gnt  output  4  one-hot grant, registered.
REQ-007 Port: gnt_id  output  2  binary index of granted requester, registered.
REQ-008 Port: gnt_valid  output  1  high while any grant is held, registered.

Function
REQ-009 The block SHALL have two states: IDLE (no owner) and GRANT (owner held).
REQ-010 gnt SHALL be zero or one-hot; gnt_valid SHALL equal |gnt; gnt_id SHALL encode the set bit of gnt and hold its last value when gnt = 0.
REQ-011 An arbitration event SHALL be any edge in IDLE with req != 0, or any release edge in GRANT (REQ-014/015).
REQ-012 Fixed mode: winner SHALL be the highest-index asserted bit (3 > 2 > 1 > 0).
REQ-013 Round-robin mode: search SHALL start at (last_owner+1) mod 4 and go ascending with wrap; the first asserted bit wins.
REQ-014 In GRANT, the owner SHALL be released at the edge where req[owner] samples 0.
REQ-015 In GRANT, the owner SHALL be force-released at the edge ending its MAX_HOLD-th granted cycle, even with req[owner] = 1.
REQ-016 On normal release, arbitration SHALL use req with the owner bit masked; on force-release, the owner bit SHALL be masked only when another bit is asserted, else the owner is re-granted with a fresh hold count.
REQ-017 If an arbitration event finds no eligible request, the next state SHALL be IDLE with gnt = 0.
REQ-018 Latency: gnt SHALL assert on the first edge after req is sampled non-zero in IDLE (1 cycle); owner handover at release SHALL take zero idle cycles.
REQ-019 hold_cnt SHALL be 1 in the first granted cycle, increment each held cycle, and reload to 1 on every new grant (including re-grant).
REQ-020 last_owner SHALL update to the winner at every grant and SHALL be unchanged in IDLE.
REQ-021 mode SHALL be sampled only at arbitration events; changes mid-grant SHALL not affect the current owner.
REQ-022 Requests from non-owners during GRANT SHALL not preempt the owner.

Reset
REQ-023 While rst = 1 at an edge: state = IDLE, gnt = 4'b0000, gnt_id = 2'b00, gnt_valid = 0, hold_cnt = 0, last_owner = 3.
REQ-024 Reset SHALL override any in-progress grant at the same edge; req is ignored during that cycle.
REQ-025 After rst deasserts, the first grant in round-robin mode with all requests asserted SHALL go to requester 0.

Verification
REQ-026 Fixed mode, req = 4'b0110 held -> after 1 edge gnt = 4'b0100, gnt_id = 2'b10; drop req[2] -> next edge gnt = 4'b0010, gnt_id = 2'b01.
REQ-027 Round-robin, req = 4'b1111 held constant, MAX_HOLD = 8 -> grants rotate 0,1,2,3,0 with each owner held exactly 8 cycles, no gnt = 0 gap.
REQ-028 Round-robin, only req = 4'b0100 held 20 cycles -> gnt = 4'b0100 throughout (re-grant at cycles 8 and 16), gnt_valid never drops.
REQ-029 Any mode, owner 1 holds, req goes to 4'b0000 -> next edge gnt = 0, gnt_valid = 0, state IDLE, gnt_id stays 2'b01.
REQ-030 Grant held by requester 3, rst = 1 for one edge with req = 4'b1111 -> outputs zero next cycle; after release, round-robin grants requester 0 first.
REQ-031 Fixed mode owner 0, switch mode to 1 mid-grant with req = 4'b1011 -> owner 0 keeps grant until release, next winner = requester 1.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// Four-requester arbiter with fixed-priority or round-robin selection and a
// per-owner hold limit that forces rotation after MAX_HOLD granted cycles.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       mode,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid
);

    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 2;
    localparam int unsigned CW  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    hold_cnt, hold_cnt_d;
    logic [IDW-1:0]   last_owner, last_owner_d;
    logic [N-1:0]     gnt_d;
    logic [IDW-1:0]   gnt_id_d;
    logic             gnt_valid_d;

    logic             arb_en;
    logic [N-1:0]     cand;
    logic [N-1:0]     owner_bit;
    logic [N-1:0]     others;
    logic [IDW-1:0]   win_fixed;
    logic [IDW-1:0]   win_rr;
    logic [IDW-1:0]   win;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt        <= '0;
            gnt_id     <= '0;
            gnt_valid  <= 1'b0;
            hold_cnt   <= '0;
            last_owner <= IDW'(N - 1);
        end else begin
            state_q    <= state_d;
            gnt        <= gnt_d;
            gnt_id     <= gnt_id_d;
            gnt_valid  <= gnt_valid_d;
            hold_cnt   <= hold_cnt_d;
            last_owner <= last_owner_d;
        end
    end

    // Winner selection over the eligible candidate set
    always_comb begin
        win_fixed = '0;
        win_rr    = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) win_fixed = IDW'(i);
        end
        // Descending scan so the nearest bit after last_owner is written last
        for (int k = N - 1; k >= 0; k--) begin
            if (cand[IDW'(int'(last_owner) + k + 1)]) win_rr = IDW'(int'(last_owner) + k + 1);
        end
        win = mode ? win_rr : win_fixed;
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt;
        gnt_id_d     = gnt_id;
        hold_cnt_d   = hold_cnt;
        last_owner_d = last_owner;
        arb_en       = 1'b0;
        cand         = req;
        owner_bit    = N'(1) << gnt_id;
        others       = req & ~owner_bit;

        case (state_q)
            IDLE: begin
                if (req != '0) arb_en = 1'b1;
            end
            GRANT: begin
                if (!req[gnt_id]) begin
                    arb_en = 1'b1;
                    cand   = others;
                end else if (hold_cnt >= CW'(MAX_HOLD)) begin
                    // Force release: a lone owner is simply re-granted
                    arb_en = 1'b1;
                    cand   = (others != '0) ? others : req;
                end else begin
                    hold_cnt_d = hold_cnt + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (arb_en) begin
            if (cand != '0) begin
                state_d      = GRANT;
                gnt_d        = N'(1) << win;
                gnt_id_d     = win;
                hold_cnt_d   = CW'(1);
                last_owner_d = win;
            end else begin
                state_d    = IDLE;
                gnt_d      = '0;
                hold_cnt_d = '0;
            end
        end

        gnt_valid_d = |gnt_d;
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 with hand-computed expected grants.
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       mode;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arbiter_4 #(.MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mode      (mode),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_gnt;

        rst = 1'b1; req = 4'b0000; mode = 1'b0;
        step(); step();
        check("rst_gnt", 8'(gnt), 8'h0);
        check("rst_id", 8'(gnt_id), 8'h0);
        check("rst_valid", 8'(gnt_valid), 8'h0);

        // Fixed priority, then normal release hands over with no gap
        rst = 1'b0; mode = 1'b0; req = 4'b0110;
        step();
        check("fix_gnt2", 8'(gnt), 8'h4);
        check("fix_id2", 8'(gnt_id), 8'h2);
        check("fix_valid", 8'(gnt_valid), 8'h1);
        req = 4'b0010;
        step();
        check("fix_gnt1", 8'(gnt), 8'h2);
        check("fix_id1", 8'(gnt_id), 8'h1);

        // Owner drops with no other request -> idle, id retained
        req = 4'b0000;
        step();
        check("idle_gnt", 8'(gnt), 8'h0);
        check("idle_valid", 8'(gnt_valid), 8'h0);
        check("idle_id", 8'(gnt_id), 8'h1);

        // Round-robin rotation after reset, 8 cycles each
        rst = 1'b1;
        step();
        rst = 1'b0; mode = 1'b1; req = 4'b1111;
        step();
        for (int o = 0; o < 5; o++) begin
            exp_gnt = 4'b0001 << (o % 4);
            for (int c = 0; c < 8; c++) begin
                check($sformatf("rot_o%0d_c%0d", o, c), 8'(gnt), 8'(exp_gnt));
                step();
            end
        end
        check("rot_next", 8'(gnt), 8'h2);

        // Lone requester re-granted at every hold limit without a gap
        req = 4'b0100;
        step();
        for (int c = 0; c < 20; c++) begin
            check($sformatf("lone_c%0d", c), 8'({gnt_valid, gnt}), 8'h14);
            step();
        end

        // Reset overrides an active grant held by requester 3
        mode = 1'b0; req = 4'b1000;
        step();
        check("own3_gnt", 8'(gnt), 8'h8);
        rst = 1'b1; req = 4'b1111;
        step();
        check("rst3_gnt", 8'(gnt), 8'h0);
        check("rst3_id", 8'(gnt_id), 8'h0);
        check("rst3_valid", 8'(gnt_valid), 8'h0);
        rst = 1'b0; mode = 1'b1;
        step();
        check("post_rst_gnt", 8'(gnt), 8'h1);

        // Mode change mid-grant takes effect only at the next arbitration
        rst = 1'b1;
        step();
        rst = 1'b0; mode = 1'b0; req = 4'b0001;
        step();
        check("mid_gnt0", 8'(gnt), 8'h1);
        mode = 1'b1; req = 4'b1011;
        for (int c = 2; c <= 8; c++) begin
            step();
            check($sformatf("mid_hold_c%0d", c), 8'(gnt), 8'h1);
        end
        step();
        check("mid_next_gnt", 8'(gnt), 8'h2);
        check("mid_next_id", 8'(gnt_id), 8'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
